// File: rtl/adc_wr_arbiter.sv
// Shares the ADC data memory and header FIFO write ports between the command and acquisition paths.
// Optional write statistics counters are enabled by defining ADC_WR_STATS_EN.
module adc_wr_arbiter #(
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 32,
  parameter int ACQ_PRIORITY = 1
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [7:0]        cmd_reg,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic              acq_valid,
  output logic              acq_ready,
  input  logic              acq_is_hdr,
  input  logic [ADDR_W-1:0] acq_addr,
  input  logic [DATA_W-1:0] acq_data,
  input  logic              acq_last,
  input  logic              hdr_fifo_full,
  output logic              ADC_data_mem_wea,
  output logic [ADDR_W-1:0] ADC_data_mem_addra,
  output logic [DATA_W-1:0] ADC_data_mem_dina,
  output logic [DATA_W-1:0] ADC_header_fifo_din,
  output logic              ADC_header_fifo_wr_en,
  output logic [ADDR_W-1:0] addr_ptr,
  output logic              acq_active,
  output logic [15:0]       mem_wr_cnt,
  output logic [15:0]       hdr_wr_cnt
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_ACQ      = 2'd1;
  localparam logic [1:0] S_CMD      = 2'd2;
  localparam logic [1:0] S_CMD_SLOT = 2'd3;

  logic [1:0] state, state_nxt;
  logic       grant_acq, grant_cmd;
  logic       cmd_ok, acq_ok, pick_acq;
  logic       cmd_xfer, acq_xfer;

  // Grant decision: IDLE picks a winner and grants it in the same cycle;
  // ACQ holds the lock until the last word; CMD/CMD_SLOT serve one command.
  always_comb begin
    cmd_ok    = cmd_valid & ~((cmd_reg == 8'd15) & hdr_fifo_full);
    acq_ok    = acq_valid & ~(acq_is_hdr & hdr_fifo_full);
    pick_acq  = acq_valid & (~cmd_valid | (ACQ_PRIORITY != 0));
    grant_acq = 1'b0;
    grant_cmd = 1'b0;
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (pick_acq) begin
          grant_acq = 1'b1;
          if (acq_ok & acq_last) state_nxt = cmd_valid ? S_CMD_SLOT : S_IDLE;
          else                   state_nxt = S_ACQ;
        end else if (cmd_valid) begin
          grant_cmd = 1'b1;
          state_nxt = cmd_ok ? S_IDLE : S_CMD;
        end
      end
      S_ACQ: begin
        grant_acq = 1'b1;
        if (acq_ok & acq_last) state_nxt = cmd_valid ? S_CMD_SLOT : S_IDLE;
      end
      S_CMD, S_CMD_SLOT: begin
        grant_cmd = 1'b1;
        if (cmd_ok | ~cmd_valid) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Readiness is masked during reset so nothing can be accepted while held
  assign acq_ready  = resetN & grant_acq & acq_ok;
  assign cmd_ready  = resetN & grant_cmd & cmd_ok;
  assign acq_xfer   = acq_valid & acq_ready;
  assign cmd_xfer   = cmd_valid & cmd_ready;
  assign acq_active = (state == S_ACQ);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      ADC_data_mem_wea      <= 1'b0;
      ADC_data_mem_addra    <= '0;
      ADC_data_mem_dina     <= '0;
      ADC_header_fifo_din   <= '0;
      ADC_header_fifo_wr_en <= 1'b0;
      addr_ptr              <= '0;
    end else begin
      ADC_data_mem_wea      <= 1'b0;
      ADC_header_fifo_wr_en <= 1'b0;
      if (acq_xfer) begin
        if (acq_is_hdr) begin
          ADC_header_fifo_din   <= acq_data;
          ADC_header_fifo_wr_en <= 1'b1;
        end else begin
          ADC_data_mem_wea   <= 1'b1;
          ADC_data_mem_addra <= acq_addr;
          ADC_data_mem_dina  <= acq_data;
        end
      end
      if (cmd_xfer) begin
        case (cmd_reg)
          8'd13: addr_ptr <= cmd_data[ADDR_W-1:0];
          8'd14: begin
            ADC_data_mem_wea   <= 1'b1;
            ADC_data_mem_addra <= addr_ptr;
            ADC_data_mem_dina  <= cmd_data;
            addr_ptr           <= addr_ptr + 1'b1;
          end
          8'd15: begin
            ADC_header_fifo_din   <= cmd_data;
            ADC_header_fifo_wr_en <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef ADC_WR_STATS_EN
  logic [15:0] mem_cnt_q, hdr_cnt_q;

  // Saturating counters of write pulses actually issued
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      mem_cnt_q <= '0;
      hdr_cnt_q <= '0;
    end else begin
      if (ADC_data_mem_wea && mem_cnt_q != 16'hFFFF)      mem_cnt_q <= mem_cnt_q + 16'd1;
      if (ADC_header_fifo_wr_en && hdr_cnt_q != 16'hFFFF) hdr_cnt_q <= hdr_cnt_q + 16'd1;
    end
  end

  assign mem_wr_cnt = mem_cnt_q;
  assign hdr_wr_cnt = hdr_cnt_q;
`else
  assign mem_wr_cnt = 16'd0;
  assign hdr_wr_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_adc_wr_arbiter.sv
// Directed self-checking bench for adc_wr_arbiter; a second instance with
// ACQ_PRIORITY = 0 shares the inputs to check command-first arbitration.
module tb_adc_wr_arbiter;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [7:0]  cmd_reg = '0;
  logic [31:0] cmd_data = '0;
  logic        acq_valid = 1'b0;
  logic        acq_is_hdr = 1'b0;
  logic [11:0] acq_addr = '0;
  logic [31:0] acq_data = '0;
  logic        acq_last = 1'b0;
  logic        hdr_fifo_full = 1'b0;

  logic        cmd_ready, acq_ready, wea, wr_en, acq_active;
  logic [11:0] addra, addr_ptr;
  logic [31:0] dina, din;
  logic [15:0] mem_cnt, hdr_cnt;

  logic        cf_cmd_ready, cf_acq_ready, cf_wea, cf_wr_en, cf_acq_active;
  logic [11:0] cf_addra, cf_addr_ptr;
  logic [31:0] cf_dina, cf_din;
  logic [15:0] cf_mem_cnt, cf_hdr_cnt;

  int checks = 0;
  int errors = 0;
  int stalls;

  always #5 clk = ~clk;

  adc_wr_arbiter #(.ADDR_W(12), .DATA_W(32), .ACQ_PRIORITY(1)) dut (
    .clk(clk), .resetN(resetN),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_reg(cmd_reg), .cmd_data(cmd_data),
    .acq_valid(acq_valid), .acq_ready(acq_ready), .acq_is_hdr(acq_is_hdr),
    .acq_addr(acq_addr), .acq_data(acq_data), .acq_last(acq_last),
    .hdr_fifo_full(hdr_fifo_full),
    .ADC_data_mem_wea(wea), .ADC_data_mem_addra(addra), .ADC_data_mem_dina(dina),
    .ADC_header_fifo_din(din), .ADC_header_fifo_wr_en(wr_en),
    .addr_ptr(addr_ptr), .acq_active(acq_active),
    .mem_wr_cnt(mem_cnt), .hdr_wr_cnt(hdr_cnt)
  );

  adc_wr_arbiter #(.ADDR_W(12), .DATA_W(32), .ACQ_PRIORITY(0)) dut_cf (
    .clk(clk), .resetN(resetN),
    .cmd_valid(cmd_valid), .cmd_ready(cf_cmd_ready), .cmd_reg(cmd_reg), .cmd_data(cmd_data),
    .acq_valid(acq_valid), .acq_ready(cf_acq_ready), .acq_is_hdr(acq_is_hdr),
    .acq_addr(acq_addr), .acq_data(acq_data), .acq_last(acq_last),
    .hdr_fifo_full(hdr_fifo_full),
    .ADC_data_mem_wea(cf_wea), .ADC_data_mem_addra(cf_addra), .ADC_data_mem_dina(cf_dina),
    .ADC_header_fifo_din(cf_din), .ADC_header_fifo_wr_en(cf_wr_en),
    .addr_ptr(cf_addr_ptr), .acq_active(cf_acq_active),
    .mem_wr_cnt(cf_mem_cnt), .hdr_wr_cnt(cf_hdr_cnt)
  );

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] stat_exp(input int n);
`ifdef ADC_WR_STATS_EN
    return n;
`else
    return 0;
`endif
  endfunction

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic apply_stimulus(input logic [7:0] r, input logic [31:0] d, output int n_stall);
    cmd_reg = r; cmd_data = d; cmd_valid = 1'b1; n_stall = 0;
    #1;
    while (!cmd_ready && n_stall < 40) begin
      @(posedge clk); #2;
      n_stall++;
    end
    if (!cmd_ready) check_output("cmd_accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_output("rst_wea", wea, 0);
    check_output("rst_wr_en", wr_en, 0);
    check_output("rst_addr_ptr", addr_ptr, 0);
    check_output("rst_acq_active", acq_active, 0);
    check_output("rst_cmd_ready", cmd_ready, 0);
    resetN = 1'b1;
    @(posedge clk); #1;

    $display("[TB] command memory writes");
    apply_stimulus(8'd13, 32'h0000_0135, stalls);
    check_output("t1_reg13_no_wea", wea, 0);
    check_output("t1_ptr_set", addr_ptr, 32'h135);
    apply_stimulus(8'd14, 32'h2222_2222, stalls);
    check_output("t1_wea0", wea, 1);
    check_output("t1_addra0", addra, 32'h135);
    check_output("t1_dina0", dina, 32'h2222_2222);
    apply_stimulus(8'd14, 32'h4444_4444, stalls);
    check_output("t1_wea1", wea, 1);
    check_output("t1_addra1", addra, 32'h136);
    check_output("t1_dina1", dina, 32'h4444_4444);
    check_output("t1_ptr_end", addr_ptr, 32'h137);
    @(posedge clk); #1;
    check_output("t1_wea_pulse_end", wea, 0);

    $display("[TB] header writes and back-pressure");
    apply_stimulus(8'd15, 32'h3333_3333, stalls);
    check_output("t2_wr_en", wr_en, 1);
    check_output("t2_din", din, 32'h3333_3333);
    check_output("t2_no_stall", stalls, 0);
    hdr_fifo_full = 1'b1;
    fork
      apply_stimulus(8'd15, 32'h5555_5555, stalls);
      begin
        repeat (5) @(posedge clk);
        #1 hdr_fifo_full = 1'b0;
      end
    join
    check_output("t2_stall_cycles", stalls, 5);
    check_output("t2_full_wr_en", wr_en, 1);
    check_output("t2_full_din", din, 32'h5555_5555);
    @(posedge clk); #1;
    check_output("t2_single_write", wr_en, 0);

    $display("[TB] pointer wrap");
    apply_stimulus(8'd13, 32'h0000_0FFF, stalls);
    apply_stimulus(8'd14, 32'h0000_000A, stalls);
    check_output("t3_addra_top", addra, 32'hFFF);
    apply_stimulus(8'd14, 32'h0000_000B, stalls);
    check_output("t3_addra_wrap", addra, 32'h000);
    check_output("t3_dina_wrap", dina, 32'h0000_000B);
    check_output("t3_ptr_wrap", addr_ptr, 32'h001);
    apply_stimulus(8'd7, 32'hDEAD_BEEF, stalls);
    check_output("t3_other_reg_no_wea", wea, 0);
    check_output("t3_other_reg_ptr", addr_ptr, 32'h001);

    $display("[TB] arbitration");
    cmd_reg = 8'd14; cmd_data = 32'hC0DE_0001; cmd_valid = 1'b1;
    acq_is_hdr = 1'b0; acq_addr = 12'h100; acq_data = 32'hA000_0000; acq_last = 1'b0; acq_valid = 1'b1;
    #1;
    check_output("t4_acq_granted", acq_ready, 1);
    check_output("t4_cmd_held", cmd_ready, 0);
    check_output("t4_cf_cmd_granted", cf_cmd_ready, 1);
    check_output("t4_cf_acq_held", cf_acq_ready, 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check_output($sformatf("t4_burst_wea%0d", i), wea, 1);
      check_output($sformatf("t4_burst_addra%0d", i), addra, 32'h100 + i);
      check_output($sformatf("t4_burst_dina%0d", i), dina, 32'hA000_0000 + i);
      if (i == 0) begin
        check_output("t4_cf_wea", cf_wea, 1);
        check_output("t4_cf_addra", cf_addra, 32'h001);
        check_output("t4_cf_dina", cf_dina, 32'hC0DE_0001);
      end
      if (i == 1) check_output("t4_acq_active", acq_active, 1);
      if (i < 3) begin
        acq_addr = 12'h101 + 12'(i);
        acq_data = 32'hA000_0001 + i;
        acq_last = (i == 2);
        #1;
        check_output($sformatf("t4_cmd_locked_out%0d", i), cmd_ready, 0);
      end else begin
        acq_addr = 12'h200; acq_data = 32'hB000_0000; acq_last = 1'b1;
        #1;
        check_output("t4_slot_cmd_ready", cmd_ready, 1);
        check_output("t4_slot_acq_held", acq_ready, 0);
      end
    end
    @(posedge clk); #1;
    check_output("t4_slot_wea", wea, 1);
    check_output("t4_slot_addra", addra, 32'h001);
    check_output("t4_slot_dina", dina, 32'hC0DE_0001);
    check_output("t4_slot_not_active", acq_active, 0);
    cmd_valid = 1'b0;
    #1;
    check_output("t4_burst2_ready", acq_ready, 1);
    @(posedge clk); #1;
    check_output("t4_burst2_addra", addra, 32'h200);
    check_output("t4_burst2_dina", dina, 32'hB000_0000);
    acq_valid = 1'b0; acq_last = 1'b0;

    $display("[TB] mixed burst with full toggling");
    hdr_fifo_full = 1'b1;
    acq_is_hdr = 1'b1; acq_data = 32'h4EAD_0000; acq_addr = 12'h000; acq_valid = 1'b1;
    #1;
    check_output("t5_hdr_blocked", acq_ready, 0);
    @(posedge clk); #1;
    check_output("t5_no_wr_while_full", wr_en, 0);
    check_output("t5_lock_held", acq_active, 1);
    hdr_fifo_full = 1'b0;
    #1;
    check_output("t5_hdr_ready", acq_ready, 1);
    @(posedge clk); #1;
    check_output("t5_hdr_wr_en", wr_en, 1);
    check_output("t5_hdr_din", din, 32'h4EAD_0000);
    check_output("t5_hdr_no_wea", wea, 0);
    acq_is_hdr = 1'b0; acq_addr = 12'h010; acq_data = 32'hD000_0000; hdr_fifo_full = 1'b1;
    #1;
    check_output("t5_data_not_blocked", acq_ready, 1);
    @(posedge clk); #1;
    check_output("t5_d0_wea", wea, 1);
    check_output("t5_d0_addra", addra, 32'h010);
    check_output("t5_d0_dina", dina, 32'hD000_0000);
    check_output("t5_d0_no_wr_en", wr_en, 0);
    acq_addr = 12'h011; acq_data = 32'hD000_0001; acq_last = 1'b1; hdr_fifo_full = 1'b0;
    @(posedge clk); #1;
    check_output("t5_d1_addra", addra, 32'h011);
    check_output("t5_d1_dina", dina, 32'hD000_0001);
    acq_valid = 1'b0; acq_last = 1'b0;
    @(posedge clk); #1;
    check_output("t5_idle_wea", wea, 0);
    check_output("t5_unlocked", acq_active, 0);
    check_output("t5_mem_cnt", mem_cnt, stat_exp(12));
    check_output("t5_hdr_cnt", hdr_cnt, stat_exp(3));

    $display("[TB] reset mid-burst");
    acq_is_hdr = 1'b0; acq_addr = 12'h300; acq_data = 32'hE000_0000; acq_valid = 1'b1;
    @(posedge clk); #1;
    acq_addr = 12'h301; acq_data = 32'hE000_0001;
    @(posedge clk); #1;
    check_output("t6_pre_addra", addra, 32'h301);
    check_output("t6_pre_active", acq_active, 1);
    resetN = 1'b0;
    #1;
    check_output("t6_wea", wea, 0);
    check_output("t6_addra", addra, 0);
    check_output("t6_dina", dina, 0);
    check_output("t6_wr_en", wr_en, 0);
    check_output("t6_din", din, 0);
    check_output("t6_active", acq_active, 0);
    check_output("t6_ptr", addr_ptr, 0);
    check_output("t6_acq_ready", acq_ready, 0);
    check_output("t6_mem_cnt", mem_cnt, 0);
    check_output("t6_hdr_cnt", hdr_cnt, 0);
    repeat (2) begin
      @(posedge clk); #1;
      check_output("t6_no_write_in_reset", wea, 0);
    end
    acq_valid = 1'b0;
    resetN = 1'b1;
    @(posedge clk); #1;
    apply_stimulus(8'd14, 32'h7777_7777, stalls);
    check_output("t6_post_wea", wea, 1);
    check_output("t6_post_addra", addra, 0);
    check_output("t6_post_dina", dina, 32'h7777_7777);
    check_output("t6_post_ptr", addr_ptr, 1);
    @(posedge clk); #1;
    check_output("t6_post_mem_cnt", mem_cnt, stat_exp(1));
    check_output("t6_post_hdr_cnt", hdr_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
